// File: rtl/adc_stim_gen.sv
// Multi-channel AXI-Stream ADC stimulus generator: const/step/ramp/noise
// waveforms with burst gating, used in place of live ADC samples.
module adc_stim_gen #(
   parameter int DATA_WIDTH = 14,
   parameter int CHANNELS   = 2,
   parameter int NOISE_BITS = 4,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                           aclk,
   input  logic                           aresetn,
   input  logic                           enable,
   input  logic [1:0]                     cfg_mode,
   input  logic [CHANNELS*DATA_WIDTH-1:0] cfg_base,
   input  logic [CHANNELS*DATA_WIDTH-1:0] cfg_alt,
   input  logic [CNT_WIDTH-1:0]           cfg_step_len,
   input  logic [CNT_WIDTH-1:0]           cfg_on_beats,
   input  logic [CNT_WIDTH-1:0]           cfg_off_cycles,
   output logic [CHANNELS*DATA_WIDTH-1:0] m_axis_tdata,
   output logic                           m_axis_tvalid,
   input  logic                           m_axis_tready,
   output logic                           busy,
   output logic [CNT_WIDTH-1:0]           sample_cnt
);

   localparam int W = CHANNELS*DATA_WIDTH;
   localparam logic [15:0] SEED = 16'hACE1;
   localparam logic [CNT_WIDTH-1:0] ONE = 1;
   localparam logic [DATA_WIDTH-1:0] S_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] S_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

   state_t               state;
   logic [1:0]           mode_q;
   logic [W-1:0]         base_q;
   logic [W-1:0]         alt_q;
   logic [CNT_WIDTH-1:0] step_q;
   logic [CNT_WIDTH-1:0] on_q;
   logic [CNT_WIDTH-1:0] off_q;
   logic [CNT_WIDTH-1:0] burst_cnt;
   logic [CNT_WIDTH-1:0] off_cnt;
   logic [15:0]          lfsr;

   logic                 hs;
   logic [15:0]          lfsr_nxt;
   logic [CNT_WIDTH-1:0] cnt_nxt;
   logic [CNT_WIDTH-1:0] burst_nxt;

   assign hs        = m_axis_tvalid & m_axis_tready;
   assign lfsr_nxt  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   assign cnt_nxt   = (&sample_cnt) ? sample_cnt : sample_cnt + ONE;
   assign burst_nxt = burst_cnt + ONE;

   // Sample for beat k; the noise term uses the LFSR value owned by that beat.
   function automatic logic [W-1:0] gen(
      input logic [1:0]           mode,
      input logic [W-1:0]         base,
      input logic [W-1:0]         alt,
      input logic [CNT_WIDTH-1:0] step,
      input logic [CNT_WIDTH-1:0] k,
      input logic [15:0]          lf
   );
      logic [W-1:0]            r;
      logic [DATA_WIDTH-1:0]   b;
      logic [DATA_WIDTH-1:0]   a;
      logic [NOISE_BITS-1:0]   n;
      logic signed [DATA_WIDTH:0] sum;
      r = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         b = base[c*DATA_WIDTH +: DATA_WIDTH];
         a = alt[c*DATA_WIDTH +: DATA_WIDTH];
         n = lf[c +: NOISE_BITS];
         sum = $signed({b[DATA_WIDTH-1], b})
             + $signed({{(DATA_WIDTH+1-NOISE_BITS){n[NOISE_BITS-1]}}, n});
         unique case (mode)
            2'd0: r[c*DATA_WIDTH +: DATA_WIDTH] = b;
            2'd1: r[c*DATA_WIDTH +: DATA_WIDTH] = (k < step) ? b : a;
            2'd2: r[c*DATA_WIDTH +: DATA_WIDTH] = b + DATA_WIDTH'(k);
            default: begin
               if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1])
                  r[c*DATA_WIDTH +: DATA_WIDTH] = sum[DATA_WIDTH] ? S_MIN : S_MAX;
               else
                  r[c*DATA_WIDTH +: DATA_WIDTH] = sum[DATA_WIDTH-1:0];
            end
         endcase
      end
      return r;
   endfunction

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state         <= IDLE;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         busy          <= 1'b0;
         sample_cnt    <= '0;
         lfsr          <= SEED;
         burst_cnt     <= '0;
         off_cnt       <= '0;
         mode_q        <= '0;
         base_q        <= '0;
         alt_q         <= '0;
         step_q        <= '0;
         on_q          <= '0;
         off_q         <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (enable) begin
                  mode_q        <= cfg_mode;
                  base_q        <= cfg_base;
                  alt_q         <= cfg_alt;
                  step_q        <= cfg_step_len;
                  on_q          <= cfg_on_beats;
                  off_q         <= cfg_off_cycles;
                  sample_cnt    <= '0;
                  burst_cnt     <= '0;
                  lfsr          <= SEED;
                  m_axis_tdata  <= gen(cfg_mode, cfg_base, cfg_alt,
                                       cfg_step_len, '0, SEED);
                  m_axis_tvalid <= 1'b1;
                  busy          <= 1'b1;
                  state         <= ON;
               end
            end
            ON: begin
               // tvalid is always high here, so leaving needs a handshake
               if (hs) begin
                  sample_cnt   <= cnt_nxt;
                  lfsr         <= lfsr_nxt;
                  m_axis_tdata <= gen(mode_q, base_q, alt_q, step_q,
                                      cnt_nxt, lfsr_nxt);
                  if (!enable) begin
                     state         <= IDLE;
                     m_axis_tvalid <= 1'b0;
                     busy          <= 1'b0;
                  end else if (on_q != '0 && burst_nxt == on_q) begin
                     burst_cnt <= '0;
                     if (off_q != '0) begin
                        state         <= OFF;
                        m_axis_tvalid <= 1'b0;
                        off_cnt       <= ONE;
                     end
                  end else begin
                     burst_cnt <= burst_nxt;
                  end
               end
            end
            OFF: begin
               if (!enable) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (off_cnt == off_q) begin
                  state         <= ON;
                  m_axis_tvalid <= 1'b1;
               end else begin
                  off_cnt <= off_cnt + ONE;
               end
            end
            default: begin
               state         <= IDLE;
               m_axis_tvalid <= 1'b0;
               busy          <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adc_stim_gen.sv
// Scoreboard bench for adc_stim_gen: a reference model queues expected
// beats per session, a negedge monitor pops them on every handshake.
module tb_adc_stim_gen;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        enable = 1'b0;
   logic [1:0]  cfg_mode = '0;
   logic [27:0] cfg_base = '0;
   logic [27:0] cfg_alt = '0;
   logic [31:0] cfg_step_len = '0;
   logic [31:0] cfg_on_beats = '0;
   logic [31:0] cfg_off_cycles = '0;
   logic [27:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b0;
   logic        busy;
   logic [31:0] sample_cnt;

   adc_stim_gen #(
      .DATA_WIDTH(14), .CHANNELS(2), .NOISE_BITS(4), .CNT_WIDTH(32)
   ) dut (
      .aclk(aclk), .aresetn(aresetn), .enable(enable),
      .cfg_mode(cfg_mode), .cfg_base(cfg_base), .cfg_alt(cfg_alt),
      .cfg_step_len(cfg_step_len), .cfg_on_beats(cfg_on_beats),
      .cfg_off_cycles(cfg_off_cycles), .m_axis_tdata(m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .busy(busy), .sample_cnt(sample_cnt)
   );

   always #5 aclk = ~aclk;

   int checks = 0;
   int errors = 0;
   logic [27:0] exp_q[$];
   int acc_cnt = 0;
   int exp_on = 0;
   int exp_off = 0;
   int burst_len = 0;
   int gap_len = 0;
   int rdy_mode = 0;
   logic rst_q = 1'b0;
   logic prev_valid = 1'b0;
   logic prev_ready = 1'b0;
   logic [27:0] prev_data = '0;

   task automatic check(string name, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [15:0] next_lfsr(logic [15:0] x);
      logic fb;
      fb = x[15] ^ x[13] ^ x[12] ^ x[10];
      return {x[14:0], fb};
   endfunction

   // Expected beat k from the waveform rules, using plain integer arithmetic
   function automatic logic [27:0] exp_beat(int mode, logic [27:0] base,
                                            logic [27:0] alt, int step,
                                            int k, logic [15:0] lf);
      logic [27:0] r;
      int ub, ua, sb, n, s, v;
      r = '0;
      for (int c = 0; c < 2; c++) begin
         ub = int'(base[c*14 +: 14]);
         ua = int'(alt[c*14 +: 14]);
         sb = (ub >= 8192) ? ub - 16384 : ub;
         v = 0;
         case (mode)
            0: v = ub;
            1: v = (k < step) ? ub : ua;
            2: v = (ub + k) % 16384;
            default: begin
               n = int'((lf >> c) & 16'hF);
               if (n >= 8) n = n - 16;
               s = sb + n;
               if (s > 8191) s = 8191;
               if (s < -8192) s = -8192;
               v = (s < 0) ? s + 16384 : s;
            end
         endcase
         r[c*14 +: 14] = 14'(v);
      end
      return r;
   endfunction

   always @(posedge aclk) rst_q <= aresetn;

   always @(posedge aclk) begin
      #1;
      case (rdy_mode)
         0: m_axis_tready = 1'b1;
         1: m_axis_tready = ~m_axis_tready;
         2: m_axis_tready = 1'($urandom_range(0, 1));
         default: m_axis_tready = 1'b0;
      endcase
   end

   // Monitor: hold rule, burst/gap lengths, and scoreboard pops
   always @(negedge aclk) begin
      if (rst_q) begin
         if (prev_valid && !prev_ready) begin
            check("hold_valid", 64'(m_axis_tvalid), 64'd1);
            check("hold_data", 64'(m_axis_tdata), 64'(prev_data));
         end
         if (!busy) begin
            gap_len = 0;
         end else if (prev_valid && !m_axis_tvalid) begin
            if (exp_on != 0 && exp_off != 0)
               check("burst_len", 64'(burst_len), 64'(exp_on));
            burst_len = 0;
            gap_len = 1;
         end else if (!m_axis_tvalid) begin
            gap_len++;
         end else if (!prev_valid && gap_len > 0) begin
            if (exp_on != 0 && exp_off != 0)
               check("gap_len", 64'(gap_len), 64'(exp_off));
            gap_len = 0;
         end
         if (m_axis_tvalid && m_axis_tready) begin
            check("sample_cnt", 64'(sample_cnt), 64'(acc_cnt));
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL beat unexpected actual=%0h required=none",
                        m_axis_tdata);
            end else begin
               check("beat", 64'(m_axis_tdata), 64'(exp_q.pop_front()));
            end
            acc_cnt++;
            burst_len++;
         end
         prev_valid = m_axis_tvalid;
         prev_ready = m_axis_tready;
         prev_data = m_axis_tdata;
      end else begin
         prev_valid = 1'b0;
         gap_len = 0;
      end
   end

   task automatic start(int mode, logic [27:0] base, logic [27:0] alt,
                        int step, int on, int off, int nexp);
      logic [15:0] lf;
      lf = 16'hACE1;
      @(posedge aclk); #2;
      cfg_mode = 2'(mode);
      cfg_base = base;
      cfg_alt = alt;
      cfg_step_len = 32'(step);
      cfg_on_beats = 32'(on);
      cfg_off_cycles = 32'(off);
      exp_on = on;
      exp_off = off;
      acc_cnt = 0;
      burst_len = 0;
      gap_len = 0;
      exp_q.delete();
      for (int k = 0; k < nexp; k++) begin
         exp_q.push_back(exp_beat(mode, base, alt, step, k, lf));
         lf = next_lfsr(lf);
      end
      enable = 1'b1;
      @(posedge aclk); #2;
      // live config must be ignored once latched
      cfg_mode = 2'($urandom);
      cfg_base = 28'($urandom);
      cfg_alt = 28'($urandom);
      cfg_step_len = $urandom;
      cfg_on_beats = $urandom_range(1, 3);
      cfg_off_cycles = $urandom_range(1, 3);
      @(negedge aclk);
      check("first_valid", 64'(m_axis_tvalid), 64'd1);
   endtask

   task automatic wait_beats(int n, int budget);
      int c;
      c = 0;
      while (acc_cnt < n && c < budget) begin
         @(posedge aclk);
         c++;
      end
      if (acc_cnt < n) begin
         checks++;
         errors++;
         $display("FAIL wait_beats actual=%0d required=%0d", acc_cnt, n);
      end
   endtask

   task automatic wait_idle();
      int c;
      c = 0;
      @(negedge aclk);
      while (busy && c < 300) begin
         @(negedge aclk);
         c++;
      end
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_valid", 64'(m_axis_tvalid), 64'd0);
      check("final_cnt", 64'(sample_cnt), 64'(acc_cnt));
   endtask

   task automatic stop_session();
      @(posedge aclk); #2;
      enable = 1'b0;
      wait_idle();
      exp_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      logic [13:0] pat;
      logic [13:0] pexp;
      rdy_mode = 0;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      check("rst_valid", 64'(m_axis_tvalid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_cnt", 64'(sample_cnt), 64'd0);
      check("rst_data", 64'(m_axis_tdata), 64'd0);
      @(posedge aclk); #2;
      aresetn = 1'b1;

      // CONST, continuous
      start(0, {14'h123, 14'h223}, '0, 0, 0, 0, 1010);
      wait_beats(1000, 1100);
      #1;
      check("cnt_1000", 64'(sample_cnt), 64'd1000);
      stop_session();

      // gating 4 on / 3 off
      start(0, 28'h0ABC123, '0, 0, 4, 3, 80);
      pat = '0;
      pexp = '0;
      pat[0] = m_axis_tvalid;
      for (int i = 1; i < 14; i++) begin
         @(negedge aclk);
         pat[i] = m_axis_tvalid;
      end
      for (int i = 0; i < 14; i++) pexp[i] = ((i % 7) < 4);
      check("gate_pattern", 64'(pat), 64'(pexp));
      wait_beats(20, 100);
      stop_session();

      // STEP with toggling ready
      rdy_mode = 1;
      start(1, {14'h100, 14'h100}, {14'h200, 14'h200}, 5, 0, 0, 60);
      wait_beats(14, 100);
      stop_session();

      // RAMP wrap, then enable drop while stalled
      rdy_mode = 0;
      start(2, {14'h3FFE, 14'h3FFE}, '0, 0, 0, 0, 60);
      wait_beats(4, 50);
      @(posedge aclk); #2;
      rdy_mode = 3;
      m_axis_tready = 1'b0;
      enable = 1'b0;
      repeat (3) @(negedge aclk);
      check("stall_busy", 64'(busy), 64'd1);
      check("stall_valid", 64'(m_axis_tvalid), 64'd1);
      @(posedge aclk); #2;
      rdy_mode = 0;
      m_axis_tready = 1'b1;
      wait_idle();
      exp_q.delete();

      // NOISE saturation, high and low, random ready
      rdy_mode = 2;
      start(3, {14'h1FFF, 14'h1FFF}, '0, 0, 0, 0, 120);
      wait_beats(40, 400);
      stop_session();
      start(3, {14'h2000, 14'h2003}, '0, 0, 2, 2, 120);
      wait_beats(40, 600);
      stop_session();

      // reset mid-burst, then restart at base
      rdy_mode = 0;
      start(2, {14'h0010, 14'h3000}, '0, 0, 0, 0, 60);
      wait_beats(5, 50);
      @(posedge aclk); #2;
      aresetn = 1'b0;
      enable = 1'b0;
      @(posedge aclk); #2;
      aresetn = 1'b1;
      acc_cnt = 0;
      exp_q.delete();
      @(negedge aclk);
      check("mid_rst_valid", 64'(m_axis_tvalid), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_cnt", 64'(sample_cnt), 64'd0);
      start(2, {14'h0010, 14'h3000}, '0, 0, 0, 0, 60);
      wait_beats(6, 50);
      stop_session();

      // random sessions
      for (int s = 0; s < 8; s++) begin
         rdy_mode = 2;
         start(int'($urandom_range(0, 3)), 28'($urandom), 28'($urandom),
               int'($urandom_range(0, 8)), int'($urandom_range(0, 5)),
               int'($urandom_range(0, 4)), 300);
         wait_beats(30, 600);
         stop_session();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
